// File: rtl/mul_pkg.sv
// Shared types and constants for the partial-product generator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

    localparam int OPW = 32;  // operand width, four byte lanes
    localparam int PPW = 16;  // width of one unsigned 8x8 byte product
    localparam int NPP = 8;   // byte products formed per cycle

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_P1,
        ST_P2,
        ST_DONE
    } state_e;

    // Byte idx (0..3) of a 32-bit word.
    function automatic logic [7:0] byte_sel(input logic [OPW-1:0] v, input logic [1:0] idx);
        return v[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mul_byte_array.sv
// Eight unsigned 8x8 byte multipliers with per-(sew, pass) operand byte selection.
// Latency: combinational.
// Backpressure: none; the caller decides when outputs are captured.
//
// Ports:
//   i_op_a, i_op_b : latched operands (bytes a3..a0, b3..b0)
//   i_sew          : element width code, 11 yields all-zero products
//   i_pass         : 0 = rows b0/b1, 1 = rows b2/b3 (only meaningful for SEW32)
//   o_pp           : eight 16-bit products, m1 in the low slice, m8 in the high slice
module mul_byte_array
    import mul_pkg::*;
(
    input  logic [OPW-1:0]     i_op_a,
    input  logic [OPW-1:0]     i_op_b,
    input  logic [1:0]         i_sew,
    input  logic               i_pass,
    output logic [NPP*PPW-1:0] o_pp
);

    logic [1:0] w_ai [NPP];
    logic [1:0] w_bj [NPP];
    logic       w_en [NPP];
    logic [1:0] w_lo;
    logic [1:0] w_hi;

    // For SEW32 each pass multiplies all four a bytes against two b rows.
    assign w_lo = i_pass ? 2'd2 : 2'd0;
    assign w_hi = i_pass ? 2'd3 : 2'd1;

    always_comb begin
        for (int k = 0; k < NPP; k++) begin
            w_ai[k] = 2'd0;
            w_bj[k] = 2'd0;
            w_en[k] = 1'b0;
        end
        case (i_sew)
            SEW8: begin
                // Diagonal: four independent byte lanes, m5..m8 unused.
                for (int k = 0; k < 4; k++) begin
                    w_ai[k] = 2'(k);
                    w_bj[k] = 2'(k);
                    w_en[k] = 1'b1;
                end
            end
            SEW16: begin
                // Two 16-bit lanes; within a lane m1:w0, m2/m3:w1, m4:w2.
                w_ai[0] = 2'd0; w_bj[0] = 2'd0;
                w_ai[1] = 2'd1; w_bj[1] = 2'd0;
                w_ai[2] = 2'd0; w_bj[2] = 2'd1;
                w_ai[3] = 2'd1; w_bj[3] = 2'd1;
                w_ai[4] = 2'd2; w_bj[4] = 2'd2;
                w_ai[5] = 2'd3; w_bj[5] = 2'd2;
                w_ai[6] = 2'd2; w_bj[6] = 2'd3;
                w_ai[7] = 2'd3; w_bj[7] = 2'd3;
                for (int k = 0; k < NPP; k++) w_en[k] = 1'b1;
            end
            SEW32: begin
                // m1..m4 = a0..a3 x low row, m5..m8 = a0..a3 x high row,
                // giving weights m1:0, m2/m5:1, m3/m6:2, m4/m7:3, m8:4.
                for (int k = 0; k < 4; k++) begin
                    w_ai[k]     = 2'(k);
                    w_bj[k]     = w_lo;
                    w_ai[k + 4] = 2'(k);
                    w_bj[k + 4] = w_hi;
                    w_en[k]     = 1'b1;
                    w_en[k + 4] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < NPP; g++) begin : g_mul
        logic [7:0] w_a;
        logic [7:0] w_b;
        assign w_a = byte_sel(i_op_a, w_ai[g]);
        assign w_b = byte_sel(i_op_b, w_bj[g]);
        assign o_pp[g*PPW +: PPW] = w_en[g] ? (PPW'(w_a) * PPW'(w_b)) : '0;
    end

endmodule

// File: rtl/mul_pp_gen.sv
// Partial-product generator and sequencer driving carry_save_8 (start/sew and mult_out_1..8).
// Latency: accept to res_valid 3 cycles (sew 00/01), 4 cycles (sew 10); illegal sew gives err_sew next cycle.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while an operation is in flight.
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake
//   op_a, op_b, sew      : operand pair and element width (00 8b, 01 16b, 10 32b, 11 illegal)
//   csa_start, csa_sew   : start pulse and held width for carry_save_8
//   mult_out_1..8        : registered byte products, zero outside START/P1/P2 data cycles
//   res_valid            : carry_save_8 product_1/2 are final this cycle
//   err_sew              : illegal width accepted and dropped
module mul_pp_gen
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [1:0]  sew,
    output logic        csa_start,
    output logic [1:0]  csa_sew,
    output logic [15:0] mult_out_1,
    output logic [15:0] mult_out_2,
    output logic [15:0] mult_out_3,
    output logic [15:0] mult_out_4,
    output logic [15:0] mult_out_5,
    output logic [15:0] mult_out_6,
    output logic [15:0] mult_out_7,
    output logic [15:0] mult_out_8,
    output logic        res_valid,
    output logic        err_sew
);

    state_e             r_state;
    logic [OPW-1:0]     r_op_a;
    logic [OPW-1:0]     r_op_b;
    logic [1:0]         r_sew;
    logic               r_csa_start;
    logic [1:0]         r_csa_sew;
    logic [NPP*PPW-1:0] r_pp;
    logic               r_res_valid;
    logic               r_err_sew;

    logic               w_accept;
    logic               w_pass;
    logic [NPP*PPW-1:0] w_pp;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid & in_ready;
    // Products are registered one cycle ahead: in START we compute pass 1,
    // in P1 we compute pass 2, so they appear during P1 and P2 respectively.
    assign w_pass   = (r_state == ST_P1);

    mul_byte_array u_bytes (
        .i_op_a (r_op_a),
        .i_op_b (r_op_b),
        .i_sew  (r_sew),
        .i_pass (w_pass),
        .o_pp   (w_pp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sew       <= 2'b00;
            r_csa_start <= 1'b0;
            r_csa_sew   <= 2'b00;
            r_pp        <= '0;
            r_res_valid <= 1'b0;
            r_err_sew   <= 1'b0;
        end else begin
            r_csa_start <= 1'b0;
            r_res_valid <= 1'b0;
            r_err_sew   <= 1'b0;
            r_pp        <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a <= op_a;
                        r_op_b <= op_b;
                        r_sew  <= sew;
                        if (sew == 2'b11) begin
                            // Dropped: carry_save_8 never sees this operation.
                            r_err_sew <= 1'b1;
                        end else begin
                            r_state     <= ST_START;
                            r_csa_start <= 1'b1;
                            r_csa_sew   <= sew;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_P1;
                    r_pp    <= w_pp;
                end
                ST_P1: begin
                    if (r_sew == SEW32) begin
                        r_state <= ST_P2;
                        r_pp    <= w_pp;
                    end else begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                ST_P2: begin
                    r_state     <= ST_DONE;
                    r_res_valid <= 1'b1;
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_csa_sew <= 2'b00;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign csa_start  = r_csa_start;
    assign csa_sew    = r_csa_sew;
    assign res_valid  = r_res_valid;
    assign err_sew    = r_err_sew;
    assign mult_out_1 = r_pp[0*PPW +: PPW];
    assign mult_out_2 = r_pp[1*PPW +: PPW];
    assign mult_out_3 = r_pp[2*PPW +: PPW];
    assign mult_out_4 = r_pp[3*PPW +: PPW];
    assign mult_out_5 = r_pp[4*PPW +: PPW];
    assign mult_out_6 = r_pp[5*PPW +: PPW];
    assign mult_out_7 = r_pp[6*PPW +: PPW];
    assign mult_out_8 = r_pp[7*PPW +: PPW];

endmodule

// File: tb/tb_mul_pp_gen.sv
// Directed bench for mul_pp_gen: mapping, sequencing, weighted-sum reconstruction, error and reset paths.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul_pp_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [1:0]  sew = 2'b00;
    logic        csa_start;
    logic [1:0]  csa_sew;
    logic [15:0] mult_out_1, mult_out_2, mult_out_3, mult_out_4;
    logic [15:0] mult_out_5, mult_out_6, mult_out_7, mult_out_8;
    logic        res_valid;
    logic        err_sew;
    logic [127:0] mv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mv = {mult_out_8, mult_out_7, mult_out_6, mult_out_5,
                 mult_out_4, mult_out_3, mult_out_2, mult_out_1};

    mul_pp_gen dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .sew        (sew),
        .csa_start  (csa_start),
        .csa_sew    (csa_sew),
        .mult_out_1 (mult_out_1),
        .mult_out_2 (mult_out_2),
        .mult_out_3 (mult_out_3),
        .mult_out_4 (mult_out_4),
        .mult_out_5 (mult_out_5),
        .mult_out_6 (mult_out_6),
        .mult_out_7 (mult_out_7),
        .mult_out_8 (mult_out_8),
        .res_valid  (res_valid),
        .err_sew    (err_sew)
    );

    // Unsigned product of byte i of a and byte j of b.
    function automatic logic [15:0] bp(input logic [31:0] a, input logic [31:0] b, input int i, input int j);
        logic [7:0] x;
        logic [7:0] y;
        x = a[8*i +: 8];
        y = b[8*j +: 8];
        return 16'(x) * 16'(y);
    endfunction

    // Expected SEW32 pass products: m1..m4 = a0..a3 x b[lo], m5..m8 = a0..a3 x b[hi].
    function automatic logic [127:0] exp32(input logic [31:0] a, input logic [31:0] b, input int lo, input int hi);
        return {bp(a, b, 3, hi), bp(a, b, 2, hi), bp(a, b, 1, hi), bp(a, b, 0, hi),
                bp(a, b, 3, lo), bp(a, b, 2, lo), bp(a, b, 1, lo), bp(a, b, 0, lo)};
    endfunction

    // carry_save_8 reduction of one pass using byte weights m1:0, m2/m5:1, m3/m6:2, m4/m7:3, m8:4.
    function automatic logic [63:0] wsum(input logic [127:0] m);
        return 64'(m[15:0])
             + (64'(m[31:16])   << 8)  + (64'(m[79:64])   << 8)
             + (64'(m[47:32])   << 16) + (64'(m[95:80])   << 16)
             + (64'(m[63:48])   << 24) + (64'(m[111:96])  << 24)
             + (64'(m[127:112]) << 32);
    endfunction

    // Present an operand pair at a negedge, wait (bounded) for acceptance,
    // and return at the negedge of the first cycle after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s, output bit ok);
        int n;
        ok = 1'b0;
        op_a = a;
        op_b = b;
        sew = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL launch_timeout in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
        checks++; if ({csa_start, res_valid, err_sew} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b want 000", {csa_start, res_valid, err_sew}); end
        checks++; if (csa_sew !== 2'b00) begin errors++; $display("FAIL rst_csa_sew got %b want 00", csa_sew); end
        checks++; if (mv !== 128'h0) begin errors++; $display("FAIL rst_mult got %h want 0", mv); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sew8();
        bit ok;
        launch(32'h04030201, 32'h05060708, 2'b00, ok);
        if (!ok) return;
        checks++; if (csa_start !== 1'b1) begin errors++; $display("FAIL sew8_start got %0b want 1", csa_start); end
        checks++; if (csa_sew !== 2'b00) begin errors++; $display("FAIL sew8_csa_sew got %b want 00", csa_sew); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sew8_busy got %0b want 0", in_ready); end
        checks++; if (mv !== 128'h0) begin errors++; $display("FAIL sew8_start_mult got %h want 0", mv); end
        @(negedge clk);
        checks++; if (mv !== {64'h0, 16'h0014, 16'h0012, 16'h000E, 16'h0008}) begin errors++; $display("FAIL sew8_products got %h want %h", mv, {64'h0, 16'h0014, 16'h0012, 16'h000E, 16'h0008}); end
        checks++; if ({csa_start, res_valid} !== 2'b00) begin errors++; $display("FAIL sew8_p1_pulses got %b want 00", {csa_start, res_valid}); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sew8_res_valid got %0b want 1 (3 cycles after accept)", res_valid); end
        checks++; if (mv !== 128'h0) begin errors++; $display("FAIL sew8_done_mult got %h want 0", mv); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sew8_done_busy got %0b want 0", in_ready); end
        @(negedge clk);
        checks++; if ({in_ready, res_valid} !== 2'b10) begin errors++; $display("FAIL sew8_idle got %b want 10", {in_ready, res_valid}); end
    endtask

    task automatic test_sew16();
        bit ok;
        logic [63:0] p1;
        logic [63:0] p2;
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, ok);
        if (!ok) return;
        checks++; if (csa_sew !== 2'b01) begin errors++; $display("FAIL sew16_csa_sew got %b want 01", csa_sew); end
        @(negedge clk);
        checks++; if (mv !== {8{16'hFE01}}) begin errors++; $display("FAIL sew16_products got %h want all FE01", mv); end
        p1 = 64'(mult_out_1) + ((64'(mult_out_2) + 64'(mult_out_3)) << 8) + (64'(mult_out_4) << 16);
        p2 = 64'(mult_out_5) + ((64'(mult_out_6) + 64'(mult_out_7)) << 8) + (64'(mult_out_8) << 16);
        checks++; if (p1 !== 64'hFFFE0001) begin errors++; $display("FAIL sew16_product_1 got %h want FFFE0001", p1); end
        checks++; if (p2 !== 64'hFFFE0001) begin errors++; $display("FAIL sew16_product_2 got %h want FFFE0001", p2); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sew16_res_valid got %0b want 1", res_valid); end
        @(negedge clk);
    endtask

    task automatic test_sew32(input logic [31:0] a, input logic [31:0] b, input logic [63:0] want);
        bit ok;
        logic [63:0] acc;
        launch(a, b, 2'b10, ok);
        if (!ok) return;
        checks++; if ({csa_start, csa_sew} !== 3'b110) begin errors++; $display("FAIL sew32_start got %b want 110", {csa_start, csa_sew}); end
        @(negedge clk);
        checks++; if (mv !== exp32(a, b, 0, 1)) begin errors++; $display("FAIL sew32_pass1 got %h want %h", mv, exp32(a, b, 0, 1)); end
        acc = wsum(mv);
        @(negedge clk);
        checks++; if (mv !== exp32(a, b, 2, 3)) begin errors++; $display("FAIL sew32_pass2 got %h want %h", mv, exp32(a, b, 2, 3)); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL sew32_early_res got %0b want 0", res_valid); end
        acc = acc + (wsum(mv) << 16);
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sew32_res_valid got %0b want 1 (4 cycles after accept)", res_valid); end
        checks++; if (mv !== 128'h0) begin errors++; $display("FAIL sew32_done_mult got %h want 0", mv); end
        checks++; if (acc !== want) begin errors++; $display("FAIL sew32_product got %h want %h", acc, want); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sew32_idle got %0b want 1", in_ready); end
    endtask

    task automatic test_illegal();
        bit ok;
        int n_start;
        int n_res;
        int n_err;
        launch(32'h11223344, 32'h55667788, 2'b11, ok);
        if (!ok) return;
        checks++; if (err_sew !== 1'b1) begin errors++; $display("FAIL ill_err_sew got %0b want 1", err_sew); end
        checks++; if (csa_start !== 1'b0) begin errors++; $display("FAIL ill_start got %0b want 0", csa_start); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_in_ready got %0b want 1", in_ready); end
        n_start = 0; n_res = 0; n_err = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_start += int'(csa_start);
            n_res   += int'(res_valid);
            n_err   += int'(err_sew);
        end
        checks++; if ({n_start, n_res, n_err} !== 96'h0) begin errors++; $display("FAIL ill_after starts=%0d res=%0d errs=%0d want 0/0/0", n_start, n_res, n_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n_res;
        launch(32'h12345678, 32'h9ABCDEF0, 2'b10, ok);
        if (!ok) return;
        @(negedge clk);
        checks++; if (mv !== exp32(32'h12345678, 32'h9ABCDEF0, 0, 1)) begin errors++; $display("FAIL rmid_pass1 got %h want %h", mv, exp32(32'h12345678, 32'h9ABCDEF0, 0, 1)); end
        reset = 1'b1;
        #1;
        checks++; if (mv !== 128'h0) begin errors++; $display("FAIL rmid_mult got %h want 0", mv); end
        checks++; if ({in_ready, csa_sew} !== 3'b100) begin errors++; $display("FAIL rmid_state got %b want 100", {in_ready, csa_sew}); end
        @(negedge clk);
        reset = 1'b0;
        n_res = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_res += int'(res_valid);
        end
        checks++; if (n_res != 0) begin errors++; $display("FAIL rmid_no_res got %0d want 0", n_res); end
        test_sew32(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    endtask

    task automatic test_back_to_back();
        int n_acc;
        int n_res;
        int n_start;
        int n_bad;
        op_a = 32'h01010101;
        op_b = 32'h02020202;
        sew = 2'b00;
        in_valid = 1'b1;
        n_acc = 0; n_res = 0; n_start = 0; n_bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (in_ready !== ((k % 4) == 0)) n_bad++;
            n_acc   += int'(in_ready);
            n_res   += int'(res_valid);
            n_start += int'(csa_start);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (n_bad != 0) begin errors++; $display("FAIL b2b_ready_pattern got %0d bad cycles want 0", n_bad); end
        checks++; if (n_acc != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", n_acc); end
        checks++; if (n_start != 3) begin errors++; $display("FAIL b2b_starts got %0d want 3", n_start); end
        checks++; if (n_res != 3) begin errors++; $display("FAIL b2b_results got %0d want 3", n_res); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sew8();
        test_sew16();
        test_sew32(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080);
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
